// File: rtl/color_cycler_pkg.sv
// Shared mode encodings and sizing helpers for the colour cycler.
package color_cycler_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_WRAP   = 2'd1;
    localparam logic [1:0] MODE_SAT    = 2'd2;

    // Gain offset per channel: channel 0 uses i*i, channel k>=1 uses i*(i+k+1).
    function automatic int chan_offset(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    // Width that holds pixel * i * (i + off) without any truncation.
    function automatic int prod_width(input int cw, input int step_w);
        return cw + 2 * step_w + 4;
    endfunction

endpackage

// File: rtl/color_cycler_chan.sv
// One colour channel: gain multiply, wrap or clamp, and the stage-2 result register.
// COLOR_CYCLER_SAT_EN adds the clamp path; without it mode 2 wraps like mode 1.
module color_cycler_chan
    import color_cycler_pkg::*;
#(
    parameter int CW     = 8,
    parameter int STEP_W = 5,
    parameter int K      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [CW-1:0]     i_chan,
    input  logic [STEP_W-1:0] i_step,
    input  logic [1:0]        i_mode,
    output logic [CW-1:0]     o_chan
);

    localparam int PW  = prod_width(CW, STEP_W);
    localparam int OFF = chan_offset(K);

    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_gain;
    logic [PW-1:0] w_prod;
    logic          w_bypass;
    logic [CW-1:0] w_result;
    logic [CW-1:0] r_chan;

    always_comb begin
        w_idx    = PW'(i_step);
        w_gain   = w_idx * (w_idx + PW'(OFF));
        w_prod   = PW'(i_chan) * w_gain;
        w_bypass = (i_step == '0) || (i_mode == MODE_BYPASS) || (i_mode == 2'd3);
    end

`ifdef COLOR_CYCLER_SAT_EN
    logic w_over;
    assign w_over = |w_prod[PW-1:CW];

    always_comb begin
        w_result = w_prod[CW-1:0];
        if (w_bypass)
            w_result = i_chan;
        else if ((i_mode == MODE_SAT) && w_over)
            w_result = '1;
    end
`else
    // High product bits only matter for the clamp, which is not built here.
    logic w_unused_hi;
    assign w_unused_hi = ^w_prod[PW-1:CW];

    always_comb begin
        w_result = w_prod[CW-1:0];
        if (w_bypass)
            w_result = i_chan;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_chan <= '0;
        else if (i_load)
            r_chan <= w_result;
    end

    assign o_chan = r_chan;

endmodule

// File: rtl/color_cycler.sv
// Colour cycler top: step synchroniser and counter, 2-stage valid/ready pipeline, per-channel gain.
// COLOR_CYCLER_SAT_EN (see color_cycler_chan) enables saturation in mode 2.
module color_cycler
    import color_cycler_pkg::*;
#(
    parameter int CW     = 8,
    parameter int NCH    = 3,
    parameter int STEP_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NCH*CW-1:0]   in_pixel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NCH*CW-1:0]   out_pixel,
    output logic [STEP_W-1:0]   step_count
);

    logic              r_step_meta;
    logic              r_step_sync;
    logic              r_step_prev;
    logic [STEP_W-1:0] r_step_count;

    logic              r_s1_valid;
    logic [NCH*CW-1:0] r_s1_pixel;
    logic [STEP_W-1:0] r_s1_step;
    logic [1:0]        r_s1_mode;
    logic              r_s2_valid;

    logic              w_step_rise;
    logic              w_s2_free;
    logic              w_s1_move;

    assign w_step_rise = r_step_sync & ~r_step_prev;
    assign w_s2_free   = !r_s2_valid || out_ready;
    assign w_s1_move   = r_s1_valid && w_s2_free;
    assign in_ready    = !r_s1_valid || w_s1_move;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_meta  <= 1'b0;
            r_step_sync  <= 1'b0;
            r_step_prev  <= 1'b0;
            r_step_count <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_pixel   <= '0;
            r_s1_step    <= '0;
            r_s1_mode    <= MODE_BYPASS;
            r_s2_valid   <= 1'b0;
        end else begin
            r_step_meta <= step;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
            if (w_step_rise)
                r_step_count <= r_step_count + 1'b1;

            // Step index is captured before this cycle's increment lands.
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_pixel <= in_pixel;
                    r_s1_step  <= r_step_count;
                    r_s1_mode  <= mode;
                end
            end

            if (w_s2_free)
                r_s2_valid <= r_s1_valid;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        color_cycler_chan #(
            .CW     (CW),
            .STEP_W (STEP_W),
            .K      (k)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_s1_move),
            .i_chan (r_s1_pixel[k*CW +: CW]),
            .i_step (r_s1_step),
            .i_mode (r_s1_mode),
            .o_chan (out_pixel[k*CW +: CW])
        );
    end

    assign out_valid  = r_s2_valid;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_color_cycler.sv
// Self-checking bench for color_cycler: spec vectors, hand-written corner sequences, randomized traffic.
module tb_color_cycler;

    localparam int CW     = 8;
    localparam int NCH    = 3;
    localparam int STEP_W = 5;
    localparam int NSTEP  = 1 << STEP_W;

`ifdef COLOR_CYCLER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              step;
    logic [1:0]        mode;
    logic              in_valid;
    logic              in_ready;
    logic [NCH*CW-1:0] in_pixel;
    logic              out_valid;
    logic              out_ready;
    logic [NCH*CW-1:0] out_pixel;
    logic [STEP_W-1:0] step_count;

    color_cycler #(.CW(CW), .NCH(NCH), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] pix;
        int          acc;
    } sb_t;

    typedef struct {
        int          idx;
        logic [1:0]  md;
        logic [23:0] pix;
        logic [23:0] exp;
    } vec_t;

    sb_t         sb[$];
    int          due_q[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          last_pop = 0;
    int          m_cnt = 0;
    bit          prev_s = 1'b0;
    bit          mon_en = 1'b0;
    logic [23:0] last_out = '0;
    int          n_out = 0;

    // Expected pixel from the gain rules, using plain integer arithmetic.
    function automatic logic [23:0] ref_pix(input logic [23:0] pix, input int i, input logic [1:0] md);
        logic [23:0] r;
        int c, g, p;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            c = int'(pix[k*CW +: CW]);
            g = i * (i + ((k == 0) ? 0 : k + 1));
            p = c * g;
            if (i == 0 || md == 2'd0 || md == 2'd3)
                r[k*CW +: CW] = 8'(c);
            else if (md == 2'd2 && SAT_EN && p > 255)
                r[k*CW +: CW] = 8'hFF;
            else
                r[k*CW +: CW] = 8'(p % 256);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // One clock: compare outputs against the model, update the model for the coming edge.
    task automatic tick();
        bit exp_ready;
        bit exp_valid;
        int vis;
        #1;
        exp_ready = (sb.size() < 2) || out_ready;
        exp_valid = 1'b0;
        if (sb.size() > 0) begin
            vis = (sb[0].acc + 2 > last_pop + 1) ? sb[0].acc + 2 : last_pop + 1;
            exp_valid = (edge_n >= vis);
        end
        if (mon_en) begin
            check("step_count", 32'(step_count), 32'(m_cnt));
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid && out_valid)
                check("out_pixel", 32'(out_pixel), 32'(sb[0].pix));
        end
        if (reset) begin
            sb.delete();
            due_q.delete();
            m_cnt    = 0;
            prev_s   = 1'b0;
            last_pop = edge_n;
        end else begin
            if (exp_valid && out_ready) begin
                last_out = out_pixel;
                n_out++;
                void'(sb.pop_front());
                last_pop = edge_n;
            end
            if (in_valid && exp_ready)
                sb.push_back('{ref_pix(in_pixel, m_cnt, mode), edge_n});
            while (due_q.size() > 0 && due_q[0] == edge_n) begin
                void'(due_q.pop_front());
                m_cnt = (m_cnt + 1) % NSTEP;
            end
            if (step && !prev_s)
                due_q.push_back(edge_n + 2);
            prev_s = step;
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send(input logic [23:0] pix, input logic [1:0] md);
        int n0;
        n0        = n_out;
        in_valid  = 1'b1;
        in_pixel  = pix;
        mode      = md;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 10 && n_out == n0; w++)
            tick();
        check("send_delivered", 32'(n_out), 32'(n0 + 1));
    endtask

    vec_t vt[10];

    initial begin
        int c0;
        int n0;
        int sent;
        bit acc;

        vt[0] = '{0, 2'd1, 24'h102030, 24'h102030};
        vt[1] = '{0, 2'd2, 24'hABCDEF, 24'hABCDEF};
        vt[2] = '{1, 2'd1, 24'h102030, 24'h406030};
        vt[3] = '{1, 2'd2, 24'h102030, 24'h406030};
        vt[4] = '{2, 2'd1, 24'h010203, 24'h0A100C};
        vt[5] = '{4, 2'd1, 24'h102030, 24'hC00000};
        vt[6] = '{4, 2'd2, 24'h102030, SAT_EN ? 24'hFFFFFF : 24'hC00000};
        vt[7] = '{4, 2'd2, 24'h010101, 24'h1C1810};
        vt[8] = '{4, 2'd0, 24'h102030, 24'h102030};
        vt[9] = '{4, 2'd3, 24'h123456, 24'h123456};

        reset     = 1'b1;
        step      = 1'b0;
        mode      = 2'd1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        #1;
        check("rst_out_pixel", 32'(out_pixel), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_step_count", 32'(step_count), 32'h0);

        // Spec vectors, stepping the counter up to each entry's index.
        for (int v = 0; v < 10; v++) begin
            for (int g = 0; g < 2 * NSTEP && m_cnt != vt[v].idx; g++)
                pulse_step();
            send(vt[v].pix, vt[v].md);
            check($sformatf("vec%0d", v), 32'(last_out), 32'(vt[v].exp));
        end

        // Level held for 10 cycles counts once.
        c0   = m_cnt;
        step = 1'b1;
        repeat (10) tick();
        step = 1'b0;
        repeat (4) tick();
        check("held_step", 32'(step_count), 32'((c0 + 1) % NSTEP));

        // Six-pixel stream with downstream stalled in cycles 2..4.
        n0   = n_out;
        sent = 0;
        mode = 2'd1;
        for (int c = 0; c < 14; c++) begin
            in_valid  = (sent < 6);
            in_pixel  = 24'($urandom);
            out_ready = !(c >= 2 && c <= 4);
            if (c == 3) begin
                #1;
                check("bp_in_ready_low", 32'(in_ready), 32'h0);
            end
            acc = in_valid && ((sb.size() < 2) || out_ready);
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("bp_delivered", 32'(n_out - n0), 32'd6);

        // Reset with two pixels held in the pipeline.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_pixel  = 24'h445566;
        tick();
        in_pixel  = 24'h778899;
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_step_count", 32'(step_count), 32'h0);
        out_ready = 1'b1;
        tick();

        // A full lap of the counter returns to passthrough.
        for (int p = 0; p < NSTEP; p++)
            pulse_step();
        check("wrap_step_count", 32'(step_count), 32'h0);
        send(24'hABCDEF, 2'd1);
        check("wrap_passthru", 32'(last_out), 32'hABCDEF);

        // Randomized traffic against the model.
        for (int r = 0; r < 400; r++) begin
            in_valid  = ($urandom % 4) != 0;
            in_pixel  = 24'($urandom);
            mode      = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
            if ($urandom % 5 == 0) step = ~step;
            reset = ($urandom % 150) == 0;
            tick();
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step      = 1'b0;
        repeat (6) tick();
        check("drain_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
